// File: rtl/multi_digit_blob.sv
// N-digit decimal sprite renderer: double-dabble BCD conversion plus glyph ROM addressing.
// Optional leading-zero blanking via MULTI_DIGIT_BLOB_ZERO_BLANK_EN.
module multi_digit_blob #(
  parameter int          WIDTH       = 25,
  parameter int          HEIGHT      = 52,
  parameter int          GAP         = 3,
  parameter int          NUM_DIGITS  = 4,
  parameter int          VAL_W       = 14,
  parameter int          ADDR_W      = 14,
  parameter int          ROM_LATENCY = 2,
  parameter logic [23:0] COLOR       = 24'hFF_FF_FF
) (
  input  logic                    pixel_clk,
  input  logic                    reset,
  input  logic [VAL_W-1:0]        value,
  input  logic                    load,
  output logic                    busy,
  input  logic [10:0]             x,
  input  logic [9:0]              y,
  input  logic [10:0]             hcount,
  input  logic [9:0]              vcount,
  output logic [ADDR_W-1:0]       rom_addr,
  input  logic                    rom_data,
  output logic                    overlap,
  output logic [23:0]             pixel,
  output logic [4*NUM_DIGITS-1:0] digits
);

  localparam int DW         = 4 * NUM_DIGITS;
  localparam int CELL_PITCH = WIDTH + GAP;
  localparam int GLYPH_SIZE = WIDTH * HEIGHT;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  localparam logic [63:0] MAX_VAL = pow10(NUM_DIGITS) - 64'd1;

  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

  state_t           state_reg, state_next;
  logic [VAL_W-1:0] shift_reg, shift_next;
  logic [DW-1:0]    bcd_reg, bcd_next;
  logic [DW-1:0]    digits_reg, digits_next;
  logic [DW-1:0]    bcd_adj;
  logic [5:0]       count_reg, count_next;
  logic             ovf_reg, ovf_next;
  logic             busy_reg, busy_next;

  // Double-dabble correction applied to every scratch nibble before each shift.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_adj
      assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ? bcd_reg[4*gi +: 4] + 4'd3
                                                                 : bcd_reg[4*gi +: 4];
    end
  endgenerate

  always_comb begin
    state_next  = state_reg;
    shift_next  = shift_reg;
    bcd_next    = bcd_reg;
    digits_next = digits_reg;
    count_next  = count_reg;
    ovf_next    = ovf_reg;
    busy_next   = busy_reg;
    case (state_reg)
      IDLE: begin
        if (load) begin
          shift_next = value;
          bcd_next   = '0;
          count_next = '0;
          ovf_next   = {{(64-VAL_W){1'b0}}, value} > MAX_VAL;
          busy_next  = 1'b1;
          state_next = CONV;
        end
      end
      CONV: begin
        shift_next = shift_reg << 1;
        bcd_next   = {bcd_adj[DW-2:0], shift_reg[VAL_W-1]};
        count_next = count_reg + 6'd1;
        if (count_reg == 6'(VAL_W - 1)) state_next = COMMIT;
      end
      COMMIT: begin
        digits_next = ovf_reg ? {NUM_DIGITS{4'h9}} : bcd_reg;
        busy_next   = 1'b0;
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Geometry: per-cell box test and glyph address, all from the committed digits.
  logic [NUM_DIGITS-1:0] cell_hit;
  logic [NUM_DIGITS-1:0] cell_vis;
  logic [ADDR_W-1:0]     cell_addr [NUM_DIGITS];
  logic [10:0]           y_end;
  logic [9:0]            row_w;
  logic                  in_y;

  assign y_end = {1'b0, y} + 11'(HEIGHT);
  assign row_w = vcount - y;
  assign in_y  = (vcount >= y) && ({1'b0, vcount} < y_end);

`ifdef MULTI_DIGIT_BLOB_ZERO_BLANK_EN
  // A cell stays visible once any more-significant-or-equal nibble is nonzero.
  always_comb begin
    logic acc;
    acc      = 1'b0;
    cell_vis = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      acc         = acc | (digits_reg[DW-1-4*k -: 4] != 4'd0);
      cell_vis[k] = acc | (k == NUM_DIGITS - 1);
    end
  end
`else
  assign cell_vis = '1;
`endif

  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_cell
      logic [11:0] left_w;
      logic [11:0] col_w;
      logic [3:0]  nib_w;
      assign left_w         = {1'b0, x} + 12'(gi * CELL_PITCH);
      assign col_w          = {1'b0, hcount} - left_w;
      assign nib_w          = digits_reg[DW-1-4*gi -: 4];
      assign cell_hit[gi]   = ({1'b0, hcount} >= left_w) && ({1'b0, hcount} < left_w + 12'(WIDTH))
                              && in_y && cell_vis[gi];
      assign cell_addr[gi]  = ADDR_W'(32'(nib_w) * 32'(GLYPH_SIZE) + 32'(row_w) * 32'(WIDTH)
                                      + 32'(col_w));
    end
  endgenerate

  logic [ADDR_W-1:0] addr_next;
  logic              hit_next;

  always_comb begin
    addr_next = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (cell_hit[k]) addr_next = cell_addr[k];
    end
    hit_next = |cell_hit;
  end

  logic [ADDR_W-1:0]    rom_addr_reg;
  logic [ROM_LATENCY:0] hit_pipe_reg;
  logic                 overlap_reg;
  logic [23:0]          pixel_reg;

  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      shift_reg    <= '0;
      bcd_reg      <= '0;
      digits_reg   <= '0;
      count_reg    <= '0;
      ovf_reg      <= 1'b0;
      busy_reg     <= 1'b0;
      rom_addr_reg <= '0;
      hit_pipe_reg <= '0;
      overlap_reg  <= 1'b0;
      pixel_reg    <= '0;
    end else begin
      state_reg       <= state_next;
      shift_reg       <= shift_next;
      bcd_reg         <= bcd_next;
      digits_reg      <= digits_next;
      count_reg       <= count_next;
      ovf_reg         <= ovf_next;
      busy_reg        <= busy_next;
      rom_addr_reg    <= addr_next;
      hit_pipe_reg[0] <= hit_next;
      for (int i = 1; i <= ROM_LATENCY; i++) hit_pipe_reg[i] <= hit_pipe_reg[i-1];
      overlap_reg     <= hit_pipe_reg[ROM_LATENCY];
      pixel_reg       <= (hit_pipe_reg[ROM_LATENCY] && rom_data) ? COLOR : 24'h0;
    end
  end

  assign busy     = busy_reg;
  assign rom_addr = rom_addr_reg;
  assign overlap  = overlap_reg;
  assign pixel    = pixel_reg;
  assign digits   = digits_reg;

endmodule

// File: tb/tb_multi_digit_blob.sv
// Self-checking bench for multi_digit_blob: conversion timing, overflow, load rejection,
// reset abort and randomized pixel-stream geometry against a division-based reference.
module tb_multi_digit_blob;
  localparam int W  = 25;
  localparam int H  = 52;
  localparam int G  = 3;
  localparam int N  = 4;
  localparam int VW = 14;
  localparam int AW = 14;
  localparam int RL = 2;

  logic          pixel_clk = 1'b0;
  logic          reset = 1'b1;
  logic [VW-1:0] value = '0;
  logic          load = 1'b0;
  logic          busy;
  logic [10:0]   x = '0;
  logic [9:0]    y = '0;
  logic [10:0]   hcount = '0;
  logic [9:0]    vcount = '0;
  logic [AW-1:0] rom_addr;
  logic          rom_data = 1'b0;
  logic          overlap;
  logic [23:0]   pixel;
  logic [15:0]   digits;

  int checks = 0;
  int failures = 0;

  multi_digit_blob #(
    .WIDTH(W), .HEIGHT(H), .GAP(G), .NUM_DIGITS(N), .VAL_W(VW),
    .ADDR_W(AW), .ROM_LATENCY(RL), .COLOR(24'hFF_FF_FF)
  ) dut (
    .pixel_clk(pixel_clk), .reset(reset), .value(value), .load(load), .busy(busy),
    .x(x), .y(y), .hcount(hcount), .vcount(vcount), .rom_addr(rom_addr),
    .rom_data(rom_data), .overlap(overlap), .pixel(pixel), .digits(digits)
  );

  always #5 pixel_clk = ~pixel_clk;

  task automatic tick();
    @(posedge pixel_clk);
    #1;
  endtask

  // Decimal digits by plain arithmetic; saturates to all nines when out of range.
  function automatic logic [15:0] model_digits(input int unsigned v);
    logic [15:0] r;
    int unsigned t;
    if (v > 9999) return 16'h9999;
    r = '0;
    t = v;
    for (int i = 0; i < N; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic bit model_visible(input logic [15:0] d, input int k);
`ifdef MULTI_DIGIT_BLOB_ZERO_BLANK_EN
    if (k == N - 1) return 1'b1;
    for (int j = 0; j <= k; j++) if (d[4*(N-1-j) +: 4] != 4'd0) return 1'b1;
    return 1'b0;
`else
    return 1'b1;
`endif
  endfunction

  // Locate the cell by division of the offset from x by the cell pitch.
  function automatic void model_geom(input int xx, input int yy, input int hh, input int vv,
                                     input logic [15:0] d, output bit hit, output int addr);
    int rel, k, off, dig;
    hit  = 1'b0;
    addr = 0;
    if (hh >= xx && vv >= yy && vv < yy + H) begin
      rel = hh - xx;
      k   = rel / (W + G);
      off = rel % (W + G);
      if (k < N && off < W && model_visible(d, k)) begin
        dig  = int'(d[4*(N-1-k) +: 4]);
        hit  = 1'b1;
        addr = (dig * W * H + (vv - yy) * W + off) % (1 << AW);
      end
    end
  endfunction

  task automatic do_load(input int unsigned v);
    value = VW'(v);
    load  = 1'b1;
    tick();
    load  = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100 && busy; i++) tick();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL wait_idle: busy=%b required 0 within 100 cycles", busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if ({busy, overlap, rom_addr, pixel, digits} !== '0) begin
      failures++;
      $display("FAIL reset_state: busy=%b overlap=%b rom_addr=%0d pixel=%h digits=%h required all 0",
               busy, overlap, rom_addr, pixel, digits);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_convert(input int unsigned v);
    logic [15:0] exp_d;
    exp_d = model_digits(v);
    do_load(v);
    for (int k = 1; k <= VW + 1; k++) begin
      checks++;
      if (busy !== 1'b1) begin
        failures++;
        $display("FAIL busy_high v=%0d cycle=%0d: busy=%b required 1", v, k, busy);
      end
      tick();
    end
    checks++;
    if (busy !== 1'b0 || digits !== exp_d) begin
      failures++;
      $display("FAIL convert v=%0d: busy=%b digits=%h required busy=0 digits=%h", v, busy, digits, exp_d);
    end
    $display("convert value=%0d digits=%h", v, digits);
  endtask

  task automatic test_ignore_load();
    do_load(321);
    tick();
    tick();
    do_load(8765);
    wait_idle();
    checks++;
    if (digits !== model_digits(321)) begin
      failures++;
      $display("FAIL ignore_load: digits=%h required %h", digits, model_digits(321));
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL no_queue: busy=%b required 0", busy);
    end
    $display("ignore_load digits=%h", digits);
  endtask

  task automatic test_reset_mid_conv();
    do_load(4321);
    for (int i = 0; i < 5; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || digits !== 16'h0) begin
      failures++;
      $display("FAIL reset_mid_conv: busy=%b digits=%h required busy=0 digits=0000", busy, digits);
    end
    $display("reset_mid_conv busy=%b digits=%h", busy, digits);
    test_convert(567);
  endtask

  task automatic probe(input int h, input int v, input bit rd,
                       output logic [AW-1:0] a, output logic ov, output logic [23:0] px);
    hcount   = 11'(h);
    vcount   = 10'(v);
    rom_data = rd;
    tick();
    a = rom_addr;
    tick();
    tick();
    tick();
    ov = overlap;
    px = pixel;
  endtask

  task automatic test_geometry_directed();
    logic [AW-1:0] a;
    logic ov;
    logic [23:0] px;
    int exp_a1, exp_a0;
    bit exp_o1, exp_o0;
`ifdef MULTI_DIGIT_BLOB_ZERO_BLANK_EN
    exp_a1 = 0;  exp_o1 = 1'b0;
`else
    exp_a1 = 25; exp_o1 = 1'b1;
`endif
    test_convert(7);
    x = 11'd100;
    y = 10'd50;
    probe(128, 51, 1'b1, a, ov, px);
    checks++;
    if (a !== AW'(exp_a1) || ov !== exp_o1 || px !== (exp_o1 ? 24'hFFFFFF : 24'h0)) begin
      failures++;
      $display("FAIL cell1: rom_addr=%0d overlap=%b pixel=%h required %0d %b", a, ov, px, exp_a1, exp_o1);
    end
    probe(125, 51, 1'b1, a, ov, px);
    checks++;
    if (a !== '0 || ov !== 1'b0 || px !== 24'h0) begin
      failures++;
      $display("FAIL gap: rom_addr=%0d overlap=%b pixel=%h required 0 0 000000", a, ov, px);
    end
    probe(184, 51, 1'b1, a, ov, px);
    checks++;
    if (a !== AW'(9125) || ov !== 1'b1 || px !== 24'hFFFFFF) begin
      failures++;
      $display("FAIL cell3: rom_addr=%0d overlap=%b pixel=%h required 9125 1 ffffff", a, ov, px);
    end
    probe(184, 51, 1'b0, a, ov, px);
    checks++;
    if (ov !== 1'b1 || px !== 24'h0) begin
      failures++;
      $display("FAIL rom_zero: overlap=%b pixel=%h required 1 000000", ov, px);
    end
    test_convert(0);
`ifdef MULTI_DIGIT_BLOB_ZERO_BLANK_EN
    exp_a0 = 0;  exp_o0 = 1'b0;
`else
    exp_a0 = 25; exp_o0 = 1'b1;
`endif
    probe(100, 51, 1'b1, a, ov, px);
    checks++;
    if (a !== AW'(exp_a0) || ov !== exp_o0) begin
      failures++;
      $display("FAIL zero_cell0: rom_addr=%0d overlap=%b required %0d %b", a, ov, exp_a0, exp_o0);
    end
    probe(184, 51, 1'b1, a, ov, px);
    checks++;
    if (a !== AW'(25) || ov !== 1'b1) begin
      failures++;
      $display("FAIL zero_cell3: rom_addr=%0d overlap=%b required 25 1", a, ov);
    end
    $display("geometry_directed done");
  endtask

  task automatic test_geometry_random();
    int hq[200], vq[200];
    bit rq[200];
    int xx, yy, ea, ea3;
    bit eh, eh3;
    int unsigned v;
    logic [15:0] d;
    int errs;
    for (int trial = 0; trial < 6; trial++) begin
      v = (trial % 2 == 0) ? $urandom_range(0, 99) : $urandom_range(0, 16383);
      test_convert(v);
      d  = model_digits(v);
      xx = int'($urandom_range(0, 1500));
      yy = int'($urandom_range(0, 900));
      x  = 11'(xx);
      y  = 10'(yy);
      errs = 0;
      for (int c = 0; c < 200; c++) begin
        hq[c] = xx - 4 + int'($urandom_range(0, N * (W + G) + 8));
        if (hq[c] < 0) hq[c] = 0;
        vq[c] = yy - 2 + int'($urandom_range(0, H + 4));
        if (vq[c] < 0) vq[c] = 0;
        rq[c] = 1'($urandom_range(0, 1));
        hcount   = 11'(hq[c]);
        vcount   = 10'(vq[c]);
        rom_data = rq[c];
        tick();
        model_geom(xx, yy, hq[c], vq[c], d, eh, ea);
        checks++;
        if (rom_addr !== AW'(ea)) begin
          failures++; errs++;
          $display("FAIL stream_addr c=%0d h=%0d v=%0d: rom_addr=%0d required %0d", c, hq[c], vq[c], rom_addr, ea);
        end
        if (c >= 3) begin
          model_geom(xx, yy, hq[c-3], vq[c-3], d, eh3, ea3);
          checks++;
          if (overlap !== eh3 || pixel !== ((eh3 && rq[c]) ? 24'hFFFFFF : 24'h0)) begin
            failures++; errs++;
            $display("FAIL stream_pixel c=%0d: overlap=%b pixel=%h required %b %h", c, overlap, pixel,
                     eh3, (eh3 && rq[c]) ? 24'hFFFFFF : 24'h0);
          end
        end
      end
      $display("geometry_random trial=%0d value=%0d x=%0d y=%0d errors=%0d", trial, v, xx, yy, errs);
    end
  endtask

  initial begin
    test_reset();
    test_convert(1234);
    test_convert(12345);
    test_convert(9999);
    test_convert(10000);
    test_convert(16383);
    test_ignore_load();
    test_reset_mid_conv();
    for (int i = 0; i < 6; i++) test_convert($urandom_range(0, 16383));
    test_geometry_directed();
    test_geometry_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
